// File: rtl/data_mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each transaction is granted in IDLE, strobes memory for one cycle in ACCESS, completes in RESP.
module data_mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic             r0_we,
  input  logic [1:0]       r0_size,
  input  logic             r0_unsigned,
  input  logic [DEPTH-1:0] r0_addr,
  input  logic [WIDTH-1:0] r0_wdata,
  output logic             r0_done,
  output logic             r0_err,
  output logic [WIDTH-1:0] r0_rdata,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic             r1_we,
  input  logic [1:0]       r1_size,
  input  logic             r1_unsigned,
  input  logic [DEPTH-1:0] r1_addr,
  input  logic [WIDTH-1:0] r1_wdata,
  output logic             r1_done,
  output logic             r1_err,
  output logic [WIDTH-1:0] r1_rdata,
  output logic             MemWrite,
  output logic             MemRead,
  output logic             one_byte,
  output logic             two_byte,
  output logic             four_bytes,
  output logic             unsigned_load,
  output logic [DEPTH-1:0] Address,
  output logic [WIDTH-1:0] WriteData,
  input  logic [WIDTH-1:0] ReadData
);

  // state  | meaning
  // IDLE   | arbitrate, grant and latch one request
  // ACCESS | drive memory strobes for one cycle
  // RESP   | pulse done (and err) to the owner
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic             err_q, err_d;
  logic [DEPTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [DEPTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic             sel1;
  logic             gnt0, gnt1;
  logic             req_we, req_uns, req_illegal;
  logic [1:0]       req_size;
  logic [DEPTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  always_comb begin
    sel1     = r1_valid && (!r0_valid || !last_q);
    req_we   = sel1 ? r1_we       : r0_we;
    req_size = sel1 ? r1_size     : r0_size;
    req_uns  = sel1 ? r1_unsigned : r0_unsigned;
    req_addr = sel1 ? r1_addr     : r0_addr;
    req_wdata = sel1 ? r1_wdata   : r0_wdata;
    req_illegal = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    case (state_q)
      IDLE: begin
        if (r0_valid || r1_valid) begin
          gnt0    = !sel1;
          gnt1    = sel1;
          owner_d = sel1;
          last_d  = sel1;
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_uns;
          err_d   = req_illegal;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_illegal) begin
            state_d = RESP;
          end else begin
            state_d     = ACCESS;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q=1 means r1 was granted last, so r0 wins the first tie after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  logic in_access, in_resp;
  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  assign r0_ready = gnt0 && !rst;
  assign r1_ready = gnt1 && !rst;

  assign MemWrite      = in_access && we_q;
  assign MemRead       = in_access && !we_q;
  assign one_byte      = in_access && (size_q == 2'b00);
  assign two_byte      = in_access && (size_q == 2'b01);
  assign four_bytes    = in_access && (size_q == 2'b10);
  assign unsigned_load = in_access && uns_q && (size_q != 2'b10);
  assign Address       = mem_addr_q;
  assign WriteData     = mem_wdata_q;

  assign r0_done  = in_resp && !owner_q;
  assign r1_done  = in_resp && owner_q;
  assign r0_err   = r0_done && err_q;
  assign r1_err   = r1_done && err_q;
  assign r0_rdata = (r0_done && !we_q && !err_q) ? ReadData : '0;
  assign r1_rdata = (r1_done && !we_q && !err_q) ? ReadData : '0;

  // addr_q is kept for the in-flight record; the memory side uses mem_addr_q
  logic unused_ok;
  assign unused_ok = ^{addr_q, wdata_q};

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small byte-addressed memory model behind it.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_valid, r0_ready, r0_we, r0_unsigned, r0_done, r0_err;
  logic [1:0]  r0_size;
  logic [11:0] r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_unsigned, r1_done, r1_err;
  logic [1:0]  r1_size;
  logic [11:0] r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
  logic        MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load;
  logic [11:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData = 32'h0;
  logic [7:0]  mem [0:4095] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.WIDTH(32), .DEPTH(12)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_size(r0_size),
    .r0_unsigned(r0_unsigned), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_size(r1_size),
    .r1_unsigned(r1_unsigned), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .one_byte(one_byte), .two_byte(two_byte),
    .four_bytes(four_bytes), .unsigned_load(unsigned_load),
    .Address(Address), .WriteData(WriteData), .ReadData(ReadData)
  );

  // little-endian memory; loads extended here according to unsigned_load
  always @(posedge clk) begin
    if (MemWrite) begin
      mem[Address] <= WriteData[7:0];
      if (two_byte || four_bytes) mem[Address + 12'd1] <= WriteData[15:8];
      if (four_bytes) begin
        mem[Address + 12'd2] <= WriteData[23:16];
        mem[Address + 12'd3] <= WriteData[31:24];
      end
    end
    if (MemRead) begin
      if (one_byte)
        ReadData <= unsigned_load ? {24'h0, mem[Address]}
                                  : {{24{mem[Address][7]}}, mem[Address]};
      else if (two_byte)
        ReadData <= unsigned_load ? {16'h0, mem[Address + 12'd1], mem[Address]}
                                  : {{16{mem[Address + 12'd1][7]}}, mem[Address + 12'd1], mem[Address]};
      else
        ReadData <= {mem[Address + 12'd3], mem[Address + 12'd2], mem[Address + 12'd1], mem[Address]};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit n, input logic v, input logic we, input logic [1:0] sz,
                       input logic uns, input logic [11:0] a, input logic [31:0] d);
    if (!n) begin
      r0_valid = v; r0_we = we; r0_size = sz; r0_unsigned = uns; r0_addr = a; r0_wdata = d;
    end else begin
      r1_valid = v; r1_we = we; r1_size = sz; r1_unsigned = uns; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[13];

  // grant, (ACCESS), RESP, IDLE; request inputs are scrambled right after the grant
  task automatic do_txn(input vec_t v);
    logic [31:0] own_rd, oth_rd;
    @(negedge clk);
    drive(v.req, 1'b1, v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    chk("grant_ready", {r0_ready, r1_ready}, v.req ? 2'b01 : 2'b10);
    @(negedge clk);
    drive(v.req, 1'b0, ~v.we, ~v.size, ~v.uns, v.addr ^ 12'hFFF, ~v.wdata);
    #1;
    if (!v.exp_err) begin
      chk("access_strobes", {MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load},
          {v.we, !v.we, v.size == 2'b00, v.size == 2'b01, v.size == 2'b10, v.uns && v.size != 2'b10});
      chk("access_addr", Address, v.addr);
      chk("access_wdata", WriteData, v.wdata);
      chk("access_ready", {r0_ready, r1_ready, r0_done, r1_done}, 4'b0000);
      @(negedge clk);
      #1;
    end
    chk("resp_done", {r0_done, r0_err, r1_done, r1_err},
        v.req ? {2'b00, 1'b1, v.exp_err} : {1'b1, v.exp_err, 2'b00});
    chk("resp_strobes", {MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load}, 6'b0);
    own_rd = v.req ? r1_rdata : r0_rdata;
    oth_rd = v.req ? r0_rdata : r1_rdata;
    if (!v.we && !v.exp_err) chk("resp_rdata", own_rd, v.exp_rdata);
    chk("other_rdata", oth_rd, 32'h0);
    @(negedge clk);
    #1;
    chk("idle_after", {r0_done, r1_done, r0_err, r1_err}, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);

    //          req we  size   uns addr     wdata          err  rdata
    tbl[0]  = '{0, 1, 2'b10, 0, 12'h000, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{0, 0, 2'b10, 0, 12'h000, 32'h0,        0, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 2'b00, 0, 12'h004, 32'h000000FF, 0, 32'h0};
    tbl[3]  = '{1, 0, 2'b00, 0, 12'h004, 32'h0,        0, 32'hFFFFFFFF};
    tbl[4]  = '{1, 0, 2'b00, 1, 12'h004, 32'h0,        0, 32'h000000FF};
    tbl[5]  = '{0, 1, 2'b01, 0, 12'h006, 32'h00008001, 0, 32'h0};
    tbl[6]  = '{0, 0, 2'b01, 0, 12'h006, 32'h0,        0, 32'hFFFF8001};
    tbl[7]  = '{1, 0, 2'b01, 1, 12'h006, 32'h0,        0, 32'h00008001};
    tbl[8]  = '{1, 0, 2'b00, 1, 12'h001, 32'h0,        0, 32'h000000BE};
    tbl[9]  = '{0, 0, 2'b10, 0, 12'h002, 32'h0,        1, 32'h0};
    tbl[10] = '{1, 0, 2'b11, 0, 12'h000, 32'h0,        1, 32'h0};
    tbl[11] = '{0, 0, 2'b01, 0, 12'h003, 32'h0,        1, 32'h0};
    tbl[12] = '{0, 0, 2'b10, 1, 12'h004, 32'h0,        0, 32'h800100FF};

    // reset beats a simultaneous request
    @(negedge clk);
    r0_valid = 1'b1;
    #1;
    chk("rst_no_grant", {r0_ready, r1_ready}, 2'b00);
    @(negedge clk);
    r0_valid = 1'b0;
    #1;
    chk("reset_outputs", {r0_ready, r1_ready, r0_done, r1_done, r0_err, r1_err,
                          MemWrite, MemRead, one_byte, two_byte, four_bytes, unsigned_load}, 12'h0);
    chk("reset_addr_wdata", {Address, WriteData}, 44'h0);
    chk("reset_rdata", {r0_rdata, r1_rdata}, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) do_txn(tbl[i]);

    // continuous contention after reset: r0, r1, r0, r1, one grant every 3 cycles
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 12'h000, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 12'h004, 32'h0);
    for (int c = 0; c < 12; c++) begin
      logic own;
      own = ((c / 3) % 2) == 1;
      #1;
      chk("contention", {r0_ready, r1_ready, r0_done, r1_done},
          {(c % 3 == 0) && !own, (c % 3 == 0) && own,
           (c % 3 == 2) && !own, (c % 3 == 2) && own});
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 12'h0, 32'h0);
    repeat (3) @(negedge clk);

    // reset during ACCESS aborts without a done pulse and without replay
    drive(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 12'h00C, 32'h0);
    #1;
    chk("abort_grant", {r0_ready, r1_ready}, 2'b10);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 12'h00C, 32'h0);
    rst = 1'b1;
    #1;
    chk("abort_in_access", {MemRead, four_bytes, Address}, {2'b11, 12'h00C});
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 12'h008, 32'h0);
    #1;
    chk("abort_quiet", {r0_done, r0_err, r1_done, r1_err, MemWrite, MemRead,
                        one_byte, two_byte, four_bytes, unsigned_load}, 10'h0);
    chk("abort_addr", Address, 12'h000);
    chk("abort_next_grant", {r0_ready, r1_ready}, 2'b01);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 12'h008, 32'h0);
    @(negedge clk);
    #1;
    chk("abort_follow_done", {r0_done, r1_done, r1_err}, 3'b010);
    @(negedge clk);
    #1;
    chk("abort_no_replay", {r0_ready, r1_ready, r0_done, r1_done}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width; DEPTH, default 12, byte-address width.
REQ-002 Ports SHALL be, in this order:
- clk  in  1  sole clock, all state updates on posedge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- rN_valid  in  1  request from requester N, where N=0 is the core LSU and N=1 is the DMA/loader.
- rN_ready  out  1  request accepted this cycle.
- rN_we  in  1  1=store, 0=load.
- rN_size  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
- rN_unsigned  in  1  zero-extend on load.
- rN_addr  in  DEPTH  byte address.
- rN_wdata  in  WIDTH  store data.
- rN_done  out  1  one-cycle completion pulse.
- rN_err  out  1  qualifies rN_done; the access was rejected.
- rN_rdata  out  WIDTH  load data, valid while rN_done=1 and rN_we was 0.
- MemWrite, MemRead  out  1  memory strobes.
- one_byte, two_byte, four_bytes, unsigned_load  out  1  memory size/sign selects.
- Address  out  DEPTH  memory address.
- WriteData  out  WIDTH  memory store data.
- ReadData  in  WIDTH  memory load data, valid the cycle after MemRead=1.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP; the reset state SHALL be IDLE.
REQ-004 In IDLE, if any rN_valid=1, the arbiter SHALL grant exactly one requester and assert its rN_ready combinationally in that cycle.
REQ-005 On a grant, the arbiter SHALL latch owner, we, size, unsigned, addr and wdata at the same posedge.
REQ-006 Arbitration SHALL be round-robin:
- a last-grant pointer updates on every grant;
- when both requesters are valid, the one not granted last SHALL win;
- the pointer SHALL reset so that r0 wins the first tie.
REQ-007 A granted request SHALL be illegal when any of the following holds:
- size=11;
- size=01 and addr[0]=1;
- size=10 and addr[1:0]!=00.
REQ-008 An illegal request SHALL go IDLE->RESP, skipping ACCESS; no memory strobe is asserted; done=1 and err=1 in RESP.
REQ-009 A legal request SHALL go IDLE->ACCESS->RESP->IDLE, for exactly 3 cycles from grant to return to IDLE.
REQ-010 In ACCESS the arbiter SHALL drive, for exactly one cycle:
- MemWrite=we and MemRead=!we;
- Address=latched addr and WriteData=latched wdata;
- one_byte/two_byte/four_bytes one-hot from size;
- unsigned_load=latched unsigned, forced to 0 for word accesses.
REQ-011 Outside ACCESS, MemWrite, MemRead and all size selects SHALL be 0; Address and WriteData SHALL hold their last driven values.
REQ-012 In RESP the arbiter SHALL pulse done of the owner only, with err=0 for a legal access; the other requester's done and err SHALL stay 0.
REQ-013 For loads, rN_rdata in RESP SHALL equal ReadData of that cycle; outside RESP, rN_rdata SHALL be 0.
REQ-014 rN_ready SHALL be 0 in ACCESS and RESP; a requester holding valid through these states SHALL be considered in the next IDLE cycle.
REQ-015 The maximum throughput SHALL be one transaction per 3 cycles; no request SHALL be accepted in RESP, which gives no back-to-back overlap.
REQ-016 A change of rN_* inputs after the grant SHALL NOT affect the transaction in flight.

Reset
REQ-017 While rst=1 at a posedge, the next state SHALL be:
- state=IDLE and pointer favours r0;
- all ready/done/err/strobe/select outputs 0;
- Address=0, WriteData=0, rN_rdata=0.
REQ-018 rst asserted during ACCESS or RESP SHALL abort the transaction: no done pulse is issued, strobes are 0 from the next cycle, and the aborted request SHALL NOT be replayed.
REQ-019 rst has priority over any simultaneous valid; no grant occurs in a cycle where rst=1.

Verification
REQ-020 Word store then load:
- r0 store addr=0x000, wdata=0xDEADBEEF, size=10: one MemWrite cycle with four_bytes=1, then r0_done;
- r0 load of the same address: r0_rdata=0xDEADBEEF in RESP with r0_err=0.
REQ-021 Signed/unsigned byte:
- r1 byte store 0xFF to addr=0x004;
- r1 signed load returns 0xFFFFFFFF;
- r1 unsigned load returns 0x000000FF with unsigned_load=1 during ACCESS.
REQ-022 Contention: r0 and r1 valid continuously for 4 grants -> grant order r0,r1,r0,r1, each grant 3 cycles apart; done pulses only on the owner.
REQ-023 Misalignment:
- r0 word load at 0x002 -> RESP with r0_done=1 and r0_err=1, MemRead never asserted, 2 cycles from grant to IDLE;
- r1 size=11 gives the same response.
REQ-024 Reset mid-operation: r0 load at 0x00C with rst=1 during ACCESS -> no r0_done, all strobes 0 next cycle, state IDLE; a following r1 request is granted first, since the pointer has reset.
